// File: rtl/memload_pkg.sv
// AHB-lite encodings and helpers shared by the memload block.
package memload_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3
   } hsize_t;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [3:0] HPROT_NONE    = 4'd0;

   function automatic hsize_t hsize_of(input int w_data);
      return hsize_t'($clog2(w_data / 8));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with the head word visible on rd_dat; zero read latency.
// wr_rdy drops when full (writes then ignored); a push and a pop may share one cycle.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             wr_rdy,
   output logic             rd_vld,
   output logic [WIDTH-1:0] rd_dat,
   input  logic             rd_rdy
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_rdy = (count != (AW + 1)'(DEPTH));
   assign rd_vld = (count != '0);
   assign rd_dat = mem[rd_ptr];
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_rdy && rd_vld;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/memload.sv
// Decodes a biphase-mark MSB-first word stream and writes each word to memory over AHB-lite; decode latency 1 clk (3 with MEMLOAD_INPUT_SYNC_EN).
// Words queue in a 4-deep FIFO while hready is low; a word completing into a full FIFO is dropped and flags overflow.
module memload
   import memload_pkg::*;
#(
   parameter int unsigned       W_ADDR     = 32,
   parameter int unsigned       W_DATA     = 32,
   parameter logic [W_ADDR-1:0] ADDR_START = 'h2008_0000,
   parameter logic [W_ADDR-1:0] ADDR_STOP  = ADDR_START + (W_ADDR'(1) << 13),
   parameter int unsigned       SHORT_MAX  = 1,
   parameter int unsigned       LONG_MAX   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              serial_in,
   output logic [W_ADDR-1:0] ahblm_haddr,
   output logic              ahblm_hwrite,
   output logic [1:0]        ahblm_htrans,
   output logic [2:0]        ahblm_hsize,
   output logic [2:0]        ahblm_hburst,
   output logic [3:0]        ahblm_hprot,
   output logic              ahblm_hmastlock,
   output logic [W_DATA-1:0] ahblm_hwdata,
   input  logic              ahblm_hready,
   input  logic              ahblm_hresp,
   input  logic [W_DATA-1:0] ahblm_hrdata,
   output logic              done,
   output logic              err,
   output logic              overflow
);
   localparam int TW = $clog2(LONG_MAX + 2);
   localparam int CW = $clog2(W_DATA);
   localparam logic [TW-1:0] T_SAT = TW'(LONG_MAX + 1);

   logic              ser, ser_q, ser_edge;
   logic [TW-1:0]     tmr;
   logic              pend;
   logic [CW-1:0]     cnt;
   logic [W_DATA-2:0] shreg;
   logic              bit_vld, bit_val, short_first, dec_err, timeout, word_done;
   logic [W_DATA-1:0] word_dat;
   logic [W_ADDR-1:0] addr_q;
   logic              dphase_q, aphase_go, push, pop;
   logic              fifo_wr_rdy, fifo_rd_vld;
   logic [W_DATA-1:0] fifo_head;
   logic              unused_resp;

`ifdef MEMLOAD_INPUT_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], serial_in};
   end
   assign ser = sync_q[1];
`else
   assign ser = serial_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ser_q <= 1'b0;
      else        ser_q <= ser;
   end
   assign ser_edge = ser ^ ser_q;

   // A saturated timer means idle: the next edge only starts the timer.
   always_comb begin
      bit_vld     = 1'b0;
      bit_val     = 1'b0;
      short_first = 1'b0;
      dec_err     = 1'b0;
      timeout     = !ser_edge && (tmr == TW'(LONG_MAX));
      if (ser_edge && (tmr != T_SAT)) begin
         if (tmr <= TW'(SHORT_MAX)) begin
            if (pend) begin
               bit_vld = 1'b1;
               bit_val = 1'b1;
            end else begin
               short_first = 1'b1;
            end
         end else if (pend) begin
            dec_err = 1'b1;
         end else begin
            bit_vld = 1'b1;
         end
      end else if (timeout) begin
         // The last bit has no closing edge; it is settled by the timeout.
         if (cnt == CW'(W_DATA - 1)) begin
            bit_vld = 1'b1;
            bit_val = pend;
         end else if (cnt != '0) begin
            dec_err = 1'b1;
         end
      end
   end

   assign word_done = bit_vld && (cnt == CW'(W_DATA - 1));
   assign word_dat  = {shreg, bit_val};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr   <= T_SAT;
         pend  <= 1'b0;
         cnt   <= '0;
         shreg <= '0;
         err   <= 1'b0;
      end else begin
         if (ser_edge)           tmr <= TW'(1);
         else if (tmr != T_SAT)  tmr <= tmr + 1'b1;
         if (dec_err || timeout) begin
            pend <= 1'b0;
            cnt  <= '0;
         end else if (bit_vld) begin
            pend  <= 1'b0;
            cnt   <= word_done ? '0 : cnt + 1'b1;
            shreg <= word_dat[W_DATA-2:0];
         end else if (short_first) begin
            pend <= 1'b1;
         end
         if (dec_err) err <= 1'b1;
      end
   end

   assign push = word_done && !done;
   assign pop  = dphase_q && ahblm_hready;

   sync_fifo #(.DEPTH(4), .WIDTH(W_DATA)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (push),
      .wr_dat (word_dat),
      .wr_rdy (fifo_wr_rdy),
      .rd_vld (fifo_rd_vld),
      .rd_dat (fifo_head),
      .rd_rdy (pop)
   );

   // Single outstanding transfer: no new address phase while a data phase is open.
   assign done      = (addr_q == ADDR_STOP);
   assign aphase_go = fifo_rd_vld && !done && !dphase_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= ADDR_START;
         dphase_q <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (aphase_go && ahblm_hready) begin
            addr_q   <= addr_q + W_ADDR'(W_DATA / 8);
            dphase_q <= 1'b1;
         end else if (pop) begin
            dphase_q <= 1'b0;
         end
         if (word_done && !fifo_wr_rdy) overflow <= 1'b1;
      end
   end

   assign ahblm_haddr     = addr_q;
   assign ahblm_hwrite    = 1'b1;
   assign ahblm_htrans    = aphase_go ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ahblm_hsize     = hsize_of(W_DATA);
   assign ahblm_hburst    = HBURST_SINGLE;
   assign ahblm_hprot     = HPROT_NONE;
   assign ahblm_hmastlock = 1'b0;
   assign ahblm_hwdata    = dphase_q ? fifo_head : '0;
   assign unused_resp     = ahblm_hresp ^ (^ahblm_hrdata);

endmodule
